// File: rtl/mp8_pkg.sv
// Shared definitions for the 8-bit register-file sequencer: opcodes,
// instruction field positions and the sequencer state encoding.
package mp8_pkg;

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_LDI  = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam int OPC_HI = 7;
    localparam int OPC_LO = 6;
    localparam int RD_HI  = 5;
    localparam int RD_LO  = 4;
    localparam int RS_HI  = 3;
    localparam int RS_LO  = 2;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_FETCH_IMM,
        ST_MOV,
        ST_LDI,
        ST_ADD_A,
        ST_ADD_WB,
        ST_HALT
    } state_t;

endpackage

// File: rtl/regfile_bus_sequencer_if.sv
// Instruction handshake plus register-file / databus control bundle.
// master = instruction source and datapath side, slave = the sequencer.
interface regfile_bus_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2
);
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              instr_ready;
    logic              rf_clear;
    logic              rf_load;
    logic              rf_enable;
    logic [SEL_W-1:0]  rf_in_sel;
    logic [SEL_W-1:0]  rf_out_sel;
    logic [SEL_W-1:0]  rf_alu_sel;
    logic [DATA_W-1:0] imm_data;
    logic              imm_oe;
    logic              alu_latch_a;
    logic              alu_oe;
    logic              op_done;
    logic              halted;

    modport master (
        output instr, instr_valid,
        input  instr_ready, rf_clear, rf_load, rf_enable, rf_in_sel,
               rf_out_sel, rf_alu_sel, imm_data, imm_oe, alu_latch_a,
               alu_oe, op_done, halted
    );

    modport slave (
        input  instr, instr_valid,
        output instr_ready, rf_clear, rf_load, rf_enable, rf_in_sel,
               rf_out_sel, rf_alu_sel, imm_data, imm_oe, alu_latch_a,
               alu_oe, op_done, halted
    );

endinterface

// File: rtl/regfile_bus_sequencer.sv
// Instruction sequencer for the 4x8 register file and shared databus.
// All outputs decode from registered state/fields; none depends on instr.
module regfile_bus_sequencer
    import mp8_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    regfile_bus_sequencer_if.slave  bus
);

    state_t            state_q, state_d;
    logic              started_q, started_d;
    logic              halt_seen_q, halt_seen_d;
    logic [SEL_W-1:0]  rd_q, rd_d;
    logic [SEL_W-1:0]  rs_q, rs_d;
    logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              unused_instr_bits;

    assign unused_instr_bits = ^bus.instr[RS_LO-1:0];

    function automatic state_t decode_op(input logic [1:0] opc);
        state_t nxt;
        case (opc)
            OP_MOV:  nxt = ST_MOV;
            OP_LDI:  nxt = ST_FETCH_IMM;
            OP_ADD:  nxt = ST_ADD_A;
            default: nxt = ST_HALT;
        endcase
        return nxt;
    endfunction

    // started_q holds INIT for one visible cycle after reset release so the
    // register-file clear is seen by a running clock, never during reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            started_q   <= 1'b0;
            halt_seen_q <= 1'b0;
            rd_q        <= '0;
            rs_q        <= '0;
            alu_sel_q   <= '0;
            imm_q       <= '0;
        end else begin
            state_q     <= state_d;
            started_q   <= started_d;
            halt_seen_q <= halt_seen_d;
            rd_q        <= rd_d;
            rs_q        <= rs_d;
            alu_sel_q   <= alu_sel_d;
            imm_q       <= imm_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        started_d   = 1'b1;
        halt_seen_d = halt_seen_q;
        rd_d        = rd_q;
        rs_d        = rs_q;
        alu_sel_d   = alu_sel_q;
        imm_d       = imm_q;
        case (state_q)
            ST_INIT: begin
                if (started_q) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    rd_d    = bus.instr[RD_HI:RD_LO];
                    rs_d    = bus.instr[RS_HI:RS_LO];
                    state_d = decode_op(bus.instr[OPC_HI:OPC_LO]);
                end
            end
            ST_FETCH_IMM: begin
                if (bus.instr_valid) begin
                    imm_d   = bus.instr;
                    state_d = ST_LDI;
                end
            end
            ST_MOV, ST_LDI, ST_ADD_WB: begin
                state_d = ST_IDLE;
            end
            ST_ADD_A: begin
                // Operand-B select updates only here so it holds between ADDs.
                alu_sel_d = rs_q;
                state_d   = ST_ADD_WB;
            end
            ST_HALT: begin
                halt_seen_d = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_comb begin
        bus.instr_ready = (state_q == ST_IDLE) || (state_q == ST_FETCH_IMM);
        bus.rf_clear    = (state_q == ST_INIT) && started_q;
        bus.rf_load     = (state_q == ST_MOV) || (state_q == ST_LDI) ||
                          (state_q == ST_ADD_WB);
        bus.rf_enable   = (state_q == ST_MOV) || (state_q == ST_ADD_A);
        bus.rf_in_sel   = rd_q;
        bus.rf_out_sel  = (state_q == ST_ADD_A) ? rd_q : rs_q;
        bus.rf_alu_sel  = alu_sel_q;
        bus.imm_data    = imm_q;
        bus.imm_oe      = (state_q == ST_LDI);
        bus.alu_latch_a = (state_q == ST_ADD_A);
        bus.alu_oe      = (state_q == ST_ADD_WB);
        bus.op_done     = (state_q == ST_MOV) || (state_q == ST_LDI) ||
                          (state_q == ST_ADD_WB) ||
                          ((state_q == ST_HALT) && !halt_seen_q);
        bus.halted      = (state_q == ST_HALT);
    end

endmodule

// File: doc/regfile_bus_sequencer.md
Name: regfile_bus_sequencer

Overview:
- Control unit for the 4x8 register file and the shared 8-bit databus.
- Accepts 8-bit instructions over a valid/ready handshake and generates the register-file strobes and selects: load, enable, in_regselect, out_regselect, alu_regselect.
- Also generates the immediate and ALU bus-drive enables, so at most one driver is on the databus per cycle.
- Sits between the instruction source and the register file / ALU.

Parameters:
- DATA_W, 8, databus and immediate width
- SEL_W, 2, register select width (4 registers)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- instr  input  DATA_W  instruction byte, or immediate byte while in FETCH_IMM
- instr_valid  input  1  instr is valid
- instr_ready  output  1  sequencer accepts instr this cycle
- rf_clear  output  1  drives register-file reset (active-high, synchronous)
- rf_load  output  1  register-file load
- rf_enable  output  1  register-file drives databus
- rf_in_sel  output  SEL_W  destination register
- rf_out_sel  output  SEL_W  register driven onto bus
- rf_alu_sel  output  SEL_W  register routed to ALU operand B
- imm_data  output  DATA_W  immediate value
- imm_oe  output  1  sequencer drives imm_data onto databus
- alu_latch_a  output  1  ALU latches databus as operand A
- alu_oe  output  1  ALU drives A+B result onto databus
- op_done  output  1  one-cycle pulse on each instruction's final cycle
- halted  output  1  HALT executed

Behaviour:
- Instruction encoding: [7:6] opcode, [5:4] rd, [3:2] rs, [1:0] ignored.
  - Opcodes: 00 MOV rd<-rs, 01 LDI rd<-next byte, 10 ADD rd<-rd+rs, 11 HALT.
- Reset (reset=0, async):
  - State goes to INIT.
  - All outputs are 0; rf_in_sel, rf_out_sel, rf_alu_sel and imm_data are 0.
- Outputs are registered or decoded from state plus registered fields. They have no combinational path from instr.
- States and per-state outputs:
  - INIT: rf_clear=1 for exactly one cycle after reset release, then IDLE.
  - IDLE: instr_ready=1. On valid&ready, latch rd and rs, then:
    - 00 -> MOV
    - 01 -> FETCH_IMM
    - 10 -> ADD_A
    - 11 -> HALT
  - MOV (1 cycle): rf_enable=1, rf_out_sel=rs, rf_load=1, rf_in_sel=rd, op_done=1, then IDLE. rd==rs is legal and rewrites the same value.
  - FETCH_IMM: instr_ready=1. Wait any number of cycles for instr_valid. On handshake, latch instr into imm_data and go to LDI.
  - LDI (1 cycle): imm_oe=1, rf_load=1, rf_in_sel=rd, op_done=1, then IDLE.
  - ADD_A (1 cycle): rf_enable=1, rf_out_sel=rd, alu_latch_a=1, then ADD_WB.
  - ADD_WB (1 cycle): rf_alu_sel=rs, alu_oe=1, rf_load=1, rf_in_sel=rd, op_done=1, then IDLE.
    - Arithmetic is the ALU's, 8-bit modulo 256; the sequencer ignores carry.
  - HALT: halted=1 and instr_ready=0 permanently. Exit only via reset. op_done pulses once on entry.
- Latency and throughput, with acceptance in cycle T:
  - MOV writes at T+1; ready again at T+2.
  - ADD writes at T+2.
  - LDI writes 1 cycle after the immediate handshake.
- Bus exclusivity invariant: rf_enable + imm_oe + alu_oe <= 1 in every cycle, including reset and INIT.
- rf_load is never high in IDLE, FETCH_IMM, INIT or HALT.
- instr_valid while not ready: instr is ignored and not latched; the source must hold it.
- Reset asserted mid-instruction: all strobes drop immediately (async); the partial instruction is abandoned with no write.
- rf_alu_sel holds its last value outside ADD_WB. rf_out_sel and rf_in_sel hold the latched rs and rd when unused.

Decomposition:
- Shared package `mp8_pkg`:
  - opcode localparams OP_MOV, OP_LDI, OP_ADD, OP_HALT
  - state encoding enum (INIT, IDLE, FETCH_IMM, MOV, LDI, ADD_A, ADD_WB, HALT)
  - field bit positions
- Single module; no sub-module needed. The decoder is a function inside the block.

Test Plan:
- Release reset -> rf_clear=1 for exactly one cycle, then instr_ready=1 and all other strobes 0.
- LDI r2, 0x5A (instr=0x60 then 0x5A with a 3-cycle gap) -> single cycle with imm_oe=1, imm_data=0x5A, rf_load=1, rf_in_sel=2, op_done=1.
- MOV r1<-r2 (0x18) -> next cycle rf_enable=1, rf_out_sel=2, rf_load=1, rf_in_sel=1. Register model r1=0x5A.
- ADD r1<-r1+r3 (0x9C), with r1=0xF0 and r3=0x20 -> ADD_A: rf_out_sel=1, alu_latch_a=1. ADD_WB: rf_alu_sel=3, alu_oe=1, load r1. Model r1=0x10 (wrap).
- Assert reset during ADD_A -> strobes drop the same cycle; r1 is unchanged. After release, INIT then IDLE.
- HALT (0xC0) then further valid instructions -> halted=1, instr_ready stays 0, no load. Bus-exclusivity assertion passes for the whole run.
